// File: rtl/graph_fetch_engine_if.sv
// Request, FIFO-drain and dual memory-port signals of the vertex fetch engine.
// The engine connects through the slave modport; the requester/memory side uses master.
interface graph_fetch_engine_if;
    logic [31:0] v_addr_in;
    logic        valid_in;
    logic        ready_out;

    logic        pos_deq_in;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic        pos_full_out;
    logic        pos_empty_out;

    logic        neigh_deq_in;
    logic [31:0] neigh_fifo_out;
    logic        neigh_valid_out;
    logic        neigh_full_out;
    logic        neigh_empty_out;

    logic [35:0] mem_req_out;
    logic        mem_valid_out;
    logic [35:0] mem_data_in;
    logic        mem_valid_in;
    logic [35:0] mem_req_out2;
    logic        mem_valid_out2;
    logic [35:0] mem_data_in2;
    logic        mem_valid_in2;

    modport slave (
        input  v_addr_in, valid_in, pos_deq_in, neigh_deq_in,
               mem_data_in, mem_valid_in, mem_data_in2, mem_valid_in2,
        output ready_out, data_out, data_valid_out, pos_full_out, pos_empty_out,
               neigh_fifo_out, neigh_valid_out, neigh_full_out, neigh_empty_out,
               mem_req_out, mem_valid_out, mem_req_out2, mem_valid_out2
    );

    modport master (
        output v_addr_in, valid_in, pos_deq_in, neigh_deq_in,
               mem_data_in, mem_valid_in, mem_data_in2, mem_valid_in2,
        input  ready_out, data_out, data_valid_out, pos_full_out, pos_empty_out,
               neigh_fifo_out, neigh_valid_out, neigh_full_out, neigh_empty_out,
               mem_req_out, mem_valid_out, mem_req_out2, mem_valid_out2
    );
endinterface

// File: rtl/graph_fetch_engine.sv
// Vertex fetch front-end: port A fetches position words, port B neighbour IDs, each into a show-ahead FIFO.
// Optional macro GRAPH_FETCH_NULL_FILTER_EN drops 32'hFFFF_FFFF neighbour responses instead of enqueuing them.
module graph_fetch_engine #(
    parameter int DIM        = 4,
    parameter int NUM_NEIGH  = 3,
    parameter int FIFO_DEPTH = 16
) (
    input logic                 clk_in,
    input logic                 rst_in,
    graph_fetch_engine_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    DIM_C   = 4'(DIM);
    localparam logic [3:0]    NN_C    = 4'(NUM_NEIGH);
    localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] DIM_W   = CW'(DIM);
    localparam logic [CW-1:0] NN_W    = CW'(NUM_NEIGH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q;
    logic [31:0] vaddr_q;
    logic [3:0]  pos_iss_q, neigh_iss_q, pos_rcv_q, neigh_rcv_q;
    logic [3:0]  pos_rcv_d, neigh_rcv_d;
    logic [35:0] req_a_q, req_b_q;
    logic        val_a_q, val_b_q;

    logic                 active_w, pos_rsp_w, neigh_rsp_w, accept_w, ready_w;
    logic [1:0]           push_w, pop_w;
    logic [1:0][31:0]     wdata_w, head_w;
    logic [1:0][CW-1:0]   count_w;
    logic                 unused_echo;

    assign unused_echo = ^{bus.mem_data_in[35:32], bus.mem_data_in2[35:32]};

    always_comb begin
        active_w    = (state_q != IDLE);
        pos_rsp_w   = bus.mem_valid_in && active_w;
        neigh_rsp_w = bus.mem_valid_in2 && active_w;
        pos_rcv_d   = pos_rcv_q + 4'(pos_rsp_w);
        neigh_rcv_d = neigh_rcv_q + 4'(neigh_rsp_w);
        push_w[0]   = pos_rsp_w;
`ifdef GRAPH_FETCH_NULL_FILTER_EN
        push_w[1]   = neigh_rsp_w && (bus.mem_data_in2[31:0] != 32'hFFFF_FFFF);
`else
        push_w[1]   = neigh_rsp_w;
`endif
        pop_w[0]    = bus.pos_deq_in;
        pop_w[1]    = bus.neigh_deq_in;
        wdata_w[0]  = bus.mem_data_in[31:0];
        wdata_w[1]  = bus.mem_data_in2[31:0];
    end

    // Whole-vertex space is reserved here, so responses can always be pushed.
    assign ready_w  = (state_q == IDLE) &&
                      ((DEPTH_W - count_w[0]) >= DIM_W) &&
                      ((DEPTH_W - count_w[1]) >= NN_W);
    assign accept_w = bus.valid_in && ready_w;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            vaddr_q     <= '0;
            pos_iss_q   <= '0;
            neigh_iss_q <= '0;
            pos_rcv_q   <= '0;
            neigh_rcv_q <= '0;
            req_a_q     <= '0;
            req_b_q     <= '0;
            val_a_q     <= 1'b0;
            val_b_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        state_q     <= ISSUE;
                        vaddr_q     <= bus.v_addr_in;
                        pos_rcv_q   <= '0;
                        neigh_rcv_q <= '0;
                        pos_iss_q   <= 4'd1;
                        neigh_iss_q <= 4'd1;
                        req_a_q     <= {4'd0, bus.v_addr_in};
                        req_b_q     <= {4'd0, bus.v_addr_in};
                        val_a_q     <= 1'b1;
                        val_b_q     <= 1'b1;
                    end
                end
                ISSUE: begin
                    pos_rcv_q   <= pos_rcv_d;
                    neigh_rcv_q <= neigh_rcv_d;
                    if (pos_iss_q < DIM_C) begin
                        req_a_q   <= {pos_iss_q, vaddr_q};
                        val_a_q   <= 1'b1;
                        pos_iss_q <= pos_iss_q + 4'd1;
                    end else begin
                        req_a_q <= '0;
                        val_a_q <= 1'b0;
                    end
                    if (neigh_iss_q < NN_C) begin
                        req_b_q     <= {neigh_iss_q, vaddr_q};
                        val_b_q     <= 1'b1;
                        neigh_iss_q <= neigh_iss_q + 4'd1;
                    end else begin
                        req_b_q <= '0;
                        val_b_q <= 1'b0;
                    end
                    if (pos_iss_q == DIM_C && neigh_iss_q == NN_C) state_q <= WAIT;
                end
                WAIT: begin
                    pos_rcv_q   <= pos_rcv_d;
                    neigh_rcv_q <= neigh_rcv_d;
                    if (pos_rcv_d == DIM_C && neigh_rcv_d == NN_C) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Index 0 is the position FIFO, index 1 the neighbour FIFO.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [31:0]   mem_q [FIFO_DEPTH];
            logic [AW-1:0] wr_q, rd_q;
            logic [CW-1:0] cnt_q;
            logic          do_pop;

            assign do_pop = pop_w[gi] && (cnt_q != '0);

            always_ff @(posedge clk_in) begin
                if (push_w[gi]) mem_q[wr_q] <= wdata_w[gi];
            end

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (push_w[gi]) wr_q <= wr_q + AW'(1);
                    if (do_pop)     rd_q <= rd_q + AW'(1);
                    cnt_q <= cnt_q + CW'(push_w[gi]) - CW'(do_pop);
                end
            end

            assign head_w[gi]  = (cnt_q != '0) ? mem_q[rd_q] : 32'd0;
            assign count_w[gi] = cnt_q;
        end
    endgenerate

    assign bus.ready_out       = ready_w;
    assign bus.mem_req_out     = req_a_q;
    assign bus.mem_valid_out   = val_a_q;
    assign bus.mem_req_out2    = req_b_q;
    assign bus.mem_valid_out2  = val_b_q;
    assign bus.data_out        = head_w[0];
    assign bus.data_valid_out  = (count_w[0] != '0);
    assign bus.pos_empty_out   = (count_w[0] == '0);
    assign bus.pos_full_out    = (count_w[0] == DEPTH_W);
    assign bus.neigh_fifo_out  = head_w[1];
    assign bus.neigh_valid_out = (count_w[1] != '0);
    assign bus.neigh_empty_out = (count_w[1] == '0);
    assign bus.neigh_full_out  = (count_w[1] == DEPTH_W);
endmodule

// File: tb/tb_graph_fetch_engine.sv
// Directed bench for graph_fetch_engine: transaction-level model checked every cycle plus literal pins.
// Honours GRAPH_FETCH_NULL_FILTER_EN when defined for both DUT and bench.
module tb_graph_fetch_engine;
    localparam int DIM   = 4;
    localparam int NN    = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    graph_fetch_engine_if bus();

    graph_fetch_engine #(.DIM(DIM), .NUM_NEIGH(NN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    logic        vin  = 1'b0;
    logic [31:0] vadr = '0;
    logic        pdeq = 1'b0;
    logic        ndeq = 1'b0;
    logic        ma_v = 1'b0;
    logic [35:0] ma_d = '0;
    logic        mb_v = 1'b0;
    logic [35:0] mb_d = '0;

    assign bus.valid_in      = vin;
    assign bus.v_addr_in     = vadr;
    assign bus.pos_deq_in    = pdeq;
    assign bus.neigh_deq_in  = ndeq;
    assign bus.mem_valid_in  = ma_v;
    assign bus.mem_data_in   = ma_d;
    assign bus.mem_valid_in2 = mb_v;
    assign bus.mem_data_in2  = mb_d;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat         = 1;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Graph memory: pos[v][i] = v*16+i, neigh[v][k] = v+k+1, returned in order after lat cycles.
    typedef struct { logic [35:0] req; int t; } preq_t;
    preq_t qa[$], qb[$];
    preq_t ra, rb;

    function automatic logic [31:0] pos_word(input logic [31:0] v, input logic [3:0] i);
        return v * 32'd16 + 32'(i);
    endfunction

    function automatic logic [31:0] neigh_word(input logic [31:0] v, input logic [3:0] k);
`ifdef GRAPH_FETCH_NULL_FILTER_EN
        if (v == 32'd9 && k == 4'd1) return 32'hFFFF_FFFF;
`endif
        return v + 32'(k) + 32'd1;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_valid_out)  qa.push_back('{bus.mem_req_out, cyc});
        if (bus.mem_valid_out2) qb.push_back('{bus.mem_req_out2, cyc});
        ma_v = 1'b0; ma_d = '0;
        mb_v = 1'b0; mb_d = '0;
        if (qa.size() > 0 && cyc >= qa[0].t + lat - 1) begin
            ra   = qa.pop_front();
            ma_v = 1'b1;
            ma_d = {ra.req[35:32], pos_word(ra.req[31:0], ra.req[35:32])};
        end
        if (qb.size() > 0 && cyc >= qb[0].t + lat - 1) begin
            rb   = qb.pop_front();
            mb_v = 1'b1;
            mb_d = {rb.req[35:32], neigh_word(rb.req[31:0], rb.req[35:32])};
        end
    end

    // Transaction model: FIFO contents as queues, one vertex in flight, issue spans max(DIM,NN) cycles.
    logic [31:0] pq[$], nq[$];
    bit          busy = 1'b0;
    bit          acc_flag = 1'b0;
    bit          m_rdy, m_busy0;
    int          k = 0, prc = 0, nrc = 0;
    logic [31:0] m_vaddr = '0;
    localparam int M = (DIM > NN) ? DIM : NN;

    function automatic bit model_ready();
        return !busy && (DEPTH - pq.size()) >= DIM && (DEPTH - nq.size()) >= NN;
    endfunction

    always @(posedge clk) begin
        cyc++;
        acc_flag = 1'b0;
        if (rst) begin
            pq.delete(); nq.delete();
            busy = 1'b0; k = 0; prc = 0; nrc = 0; m_vaddr = '0;
        end else begin
            m_rdy   = model_ready();
            m_busy0 = busy;
            if (pdeq && pq.size() > 0) void'(pq.pop_front());
            if (ndeq && nq.size() > 0) void'(nq.pop_front());
            if (m_busy0) begin
                if (ma_v) begin pq.push_back(ma_d[31:0]); prc++; end
                if (mb_v) begin
                    nrc++;
`ifdef GRAPH_FETCH_NULL_FILTER_EN
                    if (mb_d[31:0] != 32'hFFFF_FFFF) nq.push_back(mb_d[31:0]);
`else
                    nq.push_back(mb_d[31:0]);
`endif
                end
                k++;
                if (k >= M + 1 && prc == DIM && nrc == NN) busy = 1'b0;
            end else if (vin && m_rdy) begin
                busy = 1'b1; k = 0; prc = 0; nrc = 0; m_vaddr = vadr; acc_flag = 1'b1;
            end
        end
        #2;
        chk("ready_out", bus.ready_out, model_ready());
        chk("mem_valid_out", bus.mem_valid_out, busy && k < DIM);
        chk("mem_req_out", bus.mem_req_out, (busy && k < DIM) ? {4'(k), m_vaddr} : 36'd0);
        chk("mem_valid_out2", bus.mem_valid_out2, busy && k < NN);
        chk("mem_req_out2", bus.mem_req_out2, (busy && k < NN) ? {4'(k), m_vaddr} : 36'd0);
        chk("data_valid_out", bus.data_valid_out, pq.size() > 0);
        chk("data_out", bus.data_out, (pq.size() > 0) ? pq[0] : 32'd0);
        chk("pos_empty_out", bus.pos_empty_out, pq.size() == 0);
        chk("pos_full_out", bus.pos_full_out, pq.size() == DEPTH);
        chk("neigh_valid_out", bus.neigh_valid_out, nq.size() > 0);
        chk("neigh_fifo_out", bus.neigh_fifo_out, (nq.size() > 0) ? nq[0] : 32'd0);
        chk("neigh_empty_out", bus.neigh_empty_out, nq.size() == 0);
        chk("neigh_full_out", bus.neigh_full_out, nq.size() == DEPTH);
    end

    task automatic send(input logic [31:0] v);
        bit got = 1'b0;
        @(negedge clk);
        vin = 1'b1; vadr = v;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (acc_flag) begin got = 1'b1; break; end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL accept_timeout: vertex %0d got no acceptance, required acceptance", v);
        end else $display("accept vertex %0d at cycle %0d", v, cyc);
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL idle_timeout: fetch still busy, required idle");
        end
    endtask

    task automatic pop_chk(input bit neigh, input logic [31:0] exp);
        @(negedge clk);
        if (neigh) begin
            chk("neigh_head_lit", {4'd0, bus.neigh_fifo_out}, {4'd0, exp});
            $display("pop neigh head %h", bus.neigh_fifo_out);
            ndeq = 1'b1;
        end else begin
            chk("pos_head_lit", {4'd0, bus.data_out}, {4'd0, exp});
            $display("pop pos head %h", bus.data_out);
            pdeq = 1'b1;
        end
        @(negedge clk);
        pdeq = 1'b0; ndeq = 1'b0;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pdeq = (pq.size() > 0);
            ndeq = (nq.size() > 0);
            if (!pdeq && !ndeq) break;
        end
        pdeq = 1'b0; ndeq = 1'b0;
    endtask

    logic [35:0] exp_req1 [4] = '{36'h0_0000_0001, 36'h1_0000_0001, 36'h2_0000_0001, 36'h3_0000_0001};

    initial begin
        @(negedge clk);
        chk("rst_ready", bus.ready_out, 1'b1);
        chk("rst_pos_empty", bus.pos_empty_out, 1'b1);
        chk("rst_neigh_full", bus.neigh_full_out, 1'b0);
        chk("rst_mem_req", bus.mem_req_out, 36'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single vertex, request sequence and in-order heads.
        lat = 1;
        send(32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("req_seq_lit", bus.mem_req_out, exp_req1[i]);
            $display("port A request %h", bus.mem_req_out);
            @(negedge clk);
        end
        wait_idle();
        pop_chk(0, 32'h10); pop_chk(0, 32'h11); pop_chk(0, 32'h12); pop_chk(0, 32'h13);
        pop_chk(1, 32'd2);  pop_chk(1, 32'd3);  pop_chk(1, 32'd4);
        chk("empty_after_v1", {bus.pos_empty_out, bus.neigh_empty_out}, 36'd3);

        // Back-to-back vertices with longer memory latency.
        lat = 3;
        send(32'd55);
        wait_idle();
        pop_chk(0, 32'h370); pop_chk(0, 32'h371); pop_chk(0, 32'h372); pop_chk(0, 32'h373);
        pop_chk(1, 32'd56);  pop_chk(1, 32'd57);  pop_chk(1, 32'd58);
        send(32'd64);
        wait_idle();
        pop_chk(0, 32'h400); pop_chk(0, 32'h401); pop_chk(0, 32'h402); pop_chk(0, 32'h403);
        pop_chk(1, 32'd65);  pop_chk(1, 32'd66);  pop_chk(1, 32'd67);

        // No draining: four vertices fill the position FIFO, the fifth waits for room.
        lat = 2;
        for (int v = 1; v <= 4; v++) send(32'(v));
        wait_idle();
        chk("full_after_4", bus.pos_full_out, 1'b1);
        chk("ready_held", bus.ready_out, 1'b0);
        fork
            send(32'd5);
            begin
                repeat (3) @(negedge clk);
                chk("ready_held_5th", bus.ready_out, 1'b0);
                pop_chk(0, 32'h10); pop_chk(0, 32'h11); pop_chk(0, 32'h12); pop_chk(0, 32'h13);
            end
        join
        wait_idle();
        drain_all();

        // Reset in the middle of ISSUE with data already buffered.
        lat = 3;
        send(32'd8);
        wait_idle();
        send(32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", bus.ready_out, 1'b1);
        chk("async_pos_empty", bus.pos_empty_out, 1'b1);
        chk("async_neigh_empty", bus.neigh_empty_out, 1'b1);
        chk("async_mem_valid", bus.mem_valid_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_rsp_ignored", {bus.pos_empty_out, bus.neigh_empty_out}, 36'd3);

        // Pop on empty, then pop continuously while a vertex arrives (push+pop at count 1).
        lat = 1;
        pdeq = 1'b1; ndeq = 1'b1;
        repeat (3) @(negedge clk);
        pdeq = 1'b0; ndeq = 1'b0;
        chk("pop_empty_noop", {bus.pos_empty_out, bus.neigh_empty_out}, 36'd3);
        send(32'd3);
        pdeq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pushpop_head", {4'd0, bus.data_out}, 36'h31);
        chk("pushpop_valid", bus.data_valid_out, 1'b1);
        wait_idle();
        @(negedge clk);
        pdeq = 1'b0;
        chk("pushpop_drained", bus.pos_empty_out, 1'b1);
        pop_chk(1, 32'd4); pop_chk(1, 32'd5); pop_chk(1, 32'd6);

        // Vertex 9 carries a null neighbour at k=1 when filtering is built in.
        send(32'd9);
        wait_idle();
        pop_chk(1, 32'd10);
`ifndef GRAPH_FETCH_NULL_FILTER_EN
        pop_chk(1, 32'd11);
`endif
        pop_chk(1, 32'd12);
        chk("v9_neigh_empty", bus.neigh_empty_out, 1'b1);
        chk("v9_ready", bus.ready_out, 1'b1);
        drain_all();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
